// File: rtl/bitstream_word_packer.sv
// rtl/bitstream_word_packer.sv - packs 0..8-byte input beats into 32-bit big-endian words behind a word FIFO
module bitstream_word_packer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  in_enable_byte,
    input  logic [63:0] in_val,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [6:0]  fifo_level,
    output logic [1:0]  residual_bytes,
    output logic        overflow,
    output logic [31:0] word_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Each entry is {last, data}.
    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [6:0]    level;
    logic [23:0]   acc_data;
    logic [1:0]    acc_cnt;

    logic [3:0]    n_in;
    logic [63:0]   in_masked;
    logic [87:0]   combined;
    logic [95:0]   ext;
    logic [3:0]    total;
    logic [1:0]    n_words;
    logic          pad;
    logic [1:0]    n_cand;
    logic [1:0]    n_wr;
    logic          drop;
    logic          do_read;
    logic [7:0]    free;
    logic [32:0]   cand [3];
    logic [23:0]   acc_next;
    logic [1:0]    cnt_next;
    logic [32:0]   head;

    // Merge residual and new bytes, slice candidate words, and decide how many fit in the FIFO.
    always_comb begin
        n_in      = (in_enable_byte > 4'd8) ? 4'd8 : in_enable_byte;
        // Bytes past the enabled count are zeroed so padding and residual slices come out clean.
        in_masked = in_val & ~(64'hFFFF_FFFF_FFFF_FFFF >> {n_in, 3'b000});
        combined  = {acc_data, 64'd0} | ({in_masked, 24'd0} >> {acc_cnt, 3'b000});
        ext       = {combined, 8'd0};
        total     = {2'b00, acc_cnt} + n_in;
        n_words   = total[3:2];
        pad       = flush && (total[1:0] != 2'd0);
        n_cand    = n_words + {1'b0, pad};
        do_read   = out_valid && out_ready;
        // The entry freed by this cycle's read is available to this cycle's writes.
        free      = 8'(FIFO_DEPTH) - {1'b0, level} + {7'd0, do_read};
        drop      = ({6'd0, n_cand} > free);
        n_wr      = drop ? free[1:0] : n_cand;

        // The final word written in a flush cycle carries the last marker.
        cand[0] = {flush && (n_cand == 2'd1), ext[95:64]};
        cand[1] = {flush && (n_cand == 2'd2), ext[63:32]};
        cand[2] = {flush && (n_cand == 2'd3), ext[31:0]};

        case (n_words)
            2'd0:    acc_next = ext[95:72];
            2'd1:    acc_next = ext[63:40];
            default: acc_next = ext[31:8];
        endcase
        cnt_next = total[1:0];
        if (flush) begin
            acc_next = 24'd0;
            cnt_next = 2'd0;
        end
    end

    // Pointers, occupancy, accumulator and status counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= 7'd0;
            acc_data   <= 24'd0;
            acc_cnt    <= 2'd0;
            overflow   <= 1'b0;
            word_count <= 32'd0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(n_wr);
            level    <= level + {5'd0, n_wr} - {6'd0, do_read};
            acc_data <= acc_next;
            acc_cnt  <= cnt_next;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (do_read) begin
                rd_ptr     <= rd_ptr + AW'(1);
                word_count <= word_count + 32'd1;
            end
        end
    end

    // Word storage; contents need no reset because reads are gated by occupancy.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            for (int k = 0; k < 3; k++) begin
                if (k < int'(n_wr)) begin
                    mem[wr_ptr + AW'(k)] <= cand[k];
                end
            end
        end
    end

    assign head           = mem[rd_ptr];
    assign out_valid      = (level != 7'd0);
    assign out_data       = out_valid ? head[31:0] : 32'd0;
    assign out_last       = out_valid ? head[32] : 1'b0;
    assign fifo_level     = level;
    assign residual_bytes = acc_cnt;

endmodule

// File: tb/tb_bitstream_word_packer.sv
// tb/tb_bitstream_word_packer.sv - self-checking bench for bitstream_word_packer
module tb_bitstream_word_packer;

    localparam int DEPTH = 16;

    logic        clock;
    logic        reset_n;
    logic [3:0]  in_enable_byte;
    logic [63:0] in_val;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [6:0]  fifo_level;
    logic [1:0]  residual_bytes;
    logic        overflow;
    logic [31:0] word_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a byte queue for the accumulator and a word queue for the FIFO.
    logic [7:0]  bq [$];
    logic [32:0] fq [$];
    logic        m_ovf;
    logic [31:0] m_wc;

    bitstream_word_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_enable_byte (in_enable_byte),
        .in_val         (in_val),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .fifo_level     (fifo_level),
        .residual_bytes (residual_bytes),
        .overflow       (overflow),
        .word_count     (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bq.delete();
        fq.delete();
        m_ovf = 1'b0;
        m_wc  = 32'd0;
    endtask

    task automatic model_step(input logic [3:0] nb, input logic [63:0] v, input logic fl, input logic rdy);
        logic [32:0] nw [$];
        logic [32:0] w;
        int n;
        bit rd;
        rd = (fq.size() != 0) && rdy;
        n = (nb > 4'd8) ? 8 : int'(nb);
        for (int i = 0; i < n; i++) bq.push_back(v[63-8*i -: 8]);
        while (bq.size() >= 4) begin
            w = {1'b0, bq[0], bq[1], bq[2], bq[3]};
            repeat (4) void'(bq.pop_front());
            nw.push_back(w);
        end
        if (fl && bq.size() > 0) begin
            while (bq.size() < 4) bq.push_back(8'h00);
            nw.push_back({1'b0, bq[0], bq[1], bq[2], bq[3]});
            bq.delete();
        end
        if (fl && nw.size() > 0) nw[nw.size()-1][32] = 1'b1;
        if (rd) begin
            void'(fq.pop_front());
            m_wc = m_wc + 32'd1;
        end
        foreach (nw[i]) begin
            if (fq.size() < DEPTH) fq.push_back(nw[i]);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_all();
        logic ev;
        ev = (fq.size() != 0);
        check("out_valid", out_valid, ev);
        check("out_data", out_data, ev ? fq[0][31:0] : 32'd0);
        check("out_last", out_last, ev ? fq[0][32] : 1'b0);
        check("fifo_level", fifo_level, fq.size());
        check("residual_bytes", residual_bytes, bq.size());
        check("overflow", overflow, m_ovf);
        check("word_count", word_count, m_wc);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_data"}, out_data, 32'd0);
        check({tag, "_last"}, out_last, 1'b0);
        check({tag, "_level"}, fifo_level, 7'd0);
        check({tag, "_resid"}, residual_bytes, 2'd0);
        check({tag, "_ovf"}, overflow, 1'b0);
        check({tag, "_wc"}, word_count, 32'd0);
    endtask

    task automatic cycle(input logic [3:0] nb, input logic [63:0] v, input logic fl, input logic rdy);
        in_enable_byte = nb;
        in_val         = v;
        flush          = fl;
        out_ready      = rdy;
        model_step(nb, v, fl, rdy);
        @(posedge clock);
        #1;
        check_all();
    endtask

    // Pulse reset between edges; called at posedge+1.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] v;
        logic [31:0] first_word;
        reset_n        = 1'b0;
        in_enable_byte = 4'd0;
        in_val         = 64'd0;
        flush          = 1'b0;
        out_ready      = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset");
        #2;
        reset_n = 1'b1;

        // Byte assembly across cycles.
        cycle(4'd3, 64'hAABBCC00_00000000, 1'b0, 1'b1);
        cycle(4'd1, 64'hDD000000_00000000, 1'b0, 1'b1);
        check("asm_word", out_data, 32'hAABBCCDD);
        check("asm_last", out_last, 1'b0);
        cycle(4'd0, 64'd0, 1'b0, 1'b1);
        check("asm_wc", word_count, 32'd1);

        // Two words in one cycle, then flush padding.
        cycle(4'd2, 64'h11220000_00000000, 1'b0, 1'b1);
        cycle(4'd8, 64'h33445566_778899AA, 1'b0, 1'b1);
        check("two_w0", out_data, 32'h11223344);
        check("two_resid", residual_bytes, 2'd2);
        cycle(4'd0, 64'd0, 1'b0, 1'b1);
        check("two_w1", out_data, 32'h55667788);
        cycle(4'd0, 64'd0, 1'b1, 1'b1);
        check("pad_word", out_data, 32'h99AA0000);
        check("pad_last", out_last, 1'b1);
        check("pad_resid", residual_bytes, 2'd0);
        cycle(4'd0, 64'd0, 1'b0, 1'b1);

        // Backpressure into overflow; head must hold the first word.
        first_word = 32'd0;
        for (int i = 0; i < 9; i++) begin
            v = {$urandom, $urandom};
            if (i == 0) first_word = v[63:32];
            cycle(4'd8, v, 1'b0, 1'b0);
            check("bp_head", out_data, first_word);
        end
        check("bp_level", fifo_level, 7'd16);
        check("bp_ovf", overflow, 1'b1);

        // Read and write together while full.
        cycle(4'd4, {$urandom, $urandom}, 1'b0, 1'b1);
        check("full_rw_level", fifo_level, 7'd16);
        repeat (18) cycle(4'd0, 64'd0, 1'b0, 1'b1);

        // Mid-stream reset with level 5 and residual 3.
        async_reset("rst_a");
        cycle(4'd8, {$urandom, $urandom}, 1'b0, 1'b0);
        cycle(4'd8, {$urandom, $urandom}, 1'b0, 1'b0);
        cycle(4'd7, {$urandom, $urandom}, 1'b0, 1'b0);
        check("pre_rst_level", fifo_level, 7'd5);
        check("pre_rst_resid", residual_bytes, 2'd3);
        async_reset("rst_b");
        cycle(4'd4, 64'hCAFEF00D_12345678, 1'b0, 1'b1);
        check("post_rst_word", out_data, 32'hCAFEF00D);
        cycle(4'd0, 64'd0, 1'b0, 1'b1);

        // Randomized traffic including clamped byte counts, flushes and stalls.
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom_range(0, 15)), {$urandom, $urandom},
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 6));
        end
        repeat (20) cycle(4'd0, 64'd0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
